// File: rtl/vtisa_pkg.sv
// Shared opcode constants, FSM state encoding and class-decode helpers for the vtisa core.
// VTISA_SINGLE_STEP_EN adds the STEP_WAIT state.
package vtisa_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LI   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b10000;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b10001;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
`ifdef VTISA_SINGLE_STEP_EN
    , S_STEP_WAIT = 3'd6
`endif
  } state_e;

  function automatic logic is_alu(input logic [OPC_W-1:0] op);
    return ~op[4];
  endfunction

  function automatic logic is_mem(input logic [OPC_W-1:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/vtisa_decode.sv
// Combinational instruction decode: splits the instruction register into executor fields.
module vtisa_decode
  import vtisa_pkg::*;
(
  input  logic             ir_vld,
  input  logic [7:0]       ir,
  output logic [OPC_W-1:0] opcode,
  output logic [2:0]       imm,
  output logic [2:0]       reg_idx,
  output logic             is_alu_op,
  output logic             is_mem_op,
  output logic             mem_rw,
  output logic             is_halt
);

  // Class bits are qualified by ir_vld so the post-reset ir of zero decodes to all-zero fields.
  always_comb begin
    opcode    = ir[7:3];
    imm       = ir[2:0];
    reg_idx   = ir[2:0];
    is_alu_op = ir_vld & is_alu(ir[7:3]);
    is_mem_op = ir_vld & is_mem(ir[7:3]);
    mem_rw    = ir_vld & is_mem(ir[7:3]) & ir[3];
    is_halt   = ir_vld & (ir[7:3] == OP_HALT);
  end

endmodule

// File: rtl/vtisa_sequencer.sv
// Multi-cycle fetch/decode/execute controller owning PC, accumulator and the memory port.
// VTISA_SINGLE_STEP_EN adds step/step_wait and parks between instructions.
module vtisa_sequencer
  import vtisa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [4:0]        exe_opcode,
  output logic [2:0]        exe_imm,
  output logic [2:0]        exe_register,
  output logic              exe_is_alu_op,
  output logic              exe_is_mem_op,
  output logic              exe_mem_rw,
  output logic [7:0]        exe_acc,
  input  logic [7:0]        exe_new_acc,
  output logic [7:0]        acc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef VTISA_SINGLE_STEP_EN
  ,
  input  logic              step,
  output logic              step_wait
`endif
);

`ifdef VTISA_SINGLE_STEP_EN
  localparam state_e FETCH_NEXT = S_STEP_WAIT;
`else
  localparam state_e FETCH_NEXT = S_FETCH;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        ir_q, ir_d;
  logic              ir_vld_q, ir_vld_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              halted_q, halted_d;
  logic              dec_halt;
  logic              ack_ok;
`ifdef VTISA_SINGLE_STEP_EN
  logic              step_arm_q, step_arm_d;
  logic              step_wait_q, step_wait_d;
`endif

  vtisa_decode u_decode (
    .ir_vld    (ir_vld_q),
    .ir        (ir_q),
    .opcode    (exe_opcode),
    .imm       (exe_imm),
    .reg_idx   (exe_register),
    .is_alu_op (exe_is_alu_op),
    .is_mem_op (exe_is_mem_op),
    .mem_rw    (exe_mem_rw),
    .is_halt   (dec_halt)
  );

  // Next-state and datapath updates; memory-port registers follow the state being entered.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    acc_d       = acc_q;
    ir_d        = ir_q;
    ir_vld_d    = ir_vld_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    ack_ok      = mem_req_q & mem_ack;

    case (state_q)
      S_FETCH: begin
        if (ack_ok) begin
          ir_d     = mem_rdata;
          ir_vld_d = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_halt)           state_d = S_HALT;
        else if (exe_is_alu_op) state_d = S_EXEC;
        else if (exe_is_mem_op) state_d = S_MEM;
        else                    state_d = FETCH_NEXT;
      end
      S_EXEC: state_d = S_WB;
      S_MEM: begin
        if (ack_ok) begin
          if (!exe_mem_rw) acc_d = mem_rdata;
          state_d = FETCH_NEXT;
        end
      end
      S_WB: begin
        acc_d   = exe_new_acc;
        state_d = FETCH_NEXT;
      end
      S_HALT: state_d = S_HALT;
`ifdef VTISA_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step && step_arm_q) state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM);
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if (state_d == S_MEM) begin
      mem_we_d    = exe_mem_rw;
      mem_addr_d  = ADDR_W'(ir_q[2:0]);
      mem_wdata_d = acc_d;
    end
    halted_d = (state_d == S_HALT);

`ifdef VTISA_SINGLE_STEP_EN
    // A step must be seen low before it can release another instruction.
    step_arm_d = step_arm_q | ~step;
    if ((state_q == S_STEP_WAIT) && (state_d == S_FETCH)) step_arm_d = 1'b0;
    step_wait_d = (state_d == S_STEP_WAIT);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      acc_q       <= '0;
      ir_q        <= '0;
      ir_vld_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
`ifdef VTISA_SINGLE_STEP_EN
      step_arm_q  <= 1'b0;
      step_wait_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_q        <= ir_d;
      ir_vld_q    <= ir_vld_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
`ifdef VTISA_SINGLE_STEP_EN
      step_arm_q  <= step_arm_d;
      step_wait_q <= step_wait_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign exe_acc   = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
`ifdef VTISA_SINGLE_STEP_EN
  assign step_wait = step_wait_q;
`endif

endmodule

// File: tb/tb_vtisa_sequencer.sv
// Directed bench for vtisa_sequencer with a memory responder and a registered executor model.
module tb_vtisa_sequencer;
  import vtisa_pkg::*;

  localparam logic [4:0] OP_ADDI = 5'b00001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [4:0] exe_opcode;
  logic [2:0] exe_imm, exe_register;
  logic       exe_is_alu_op, exe_is_mem_op, exe_mem_rw;
  logic [7:0] exe_acc, acc, pc;
  logic [7:0] exe_new_acc = 8'h00;
  logic       halted;
`ifdef VTISA_SINGLE_STEP_EN
  logic       step = 1'b0;
  logic       step_wait;
`endif

  logic [7:0]  mem [256];
  int unsigned ack_delay = 0;
  logic        ack_force = 1'b0;
  int unsigned wait_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  vtisa_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .exe_opcode(exe_opcode), .exe_imm(exe_imm), .exe_register(exe_register),
    .exe_is_alu_op(exe_is_alu_op), .exe_is_mem_op(exe_is_mem_op), .exe_mem_rw(exe_mem_rw),
    .exe_acc(exe_acc), .exe_new_acc(exe_new_acc),
    .acc(acc), .pc(pc), .halted(halted)
`ifdef VTISA_SINGLE_STEP_EN
    , .step(step), .step_wait(step_wait)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: ack after ack_delay wait cycles, read data valid with ack.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = ack_force | (mem_req & (wait_cnt == ack_delay));

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
  end

  // Executor model: LI loads imm, ADDI adds imm, other ALU opcodes pass acc through.
  function automatic logic [7:0] exe_model(input logic [4:0] op, input logic [2:0] imm,
                                           input logic [7:0] a);
    if (op == OP_LI)   return {5'b0, imm};
    if (op == OP_ADDI) return a + {5'b0, imm};
    return a;
  endfunction

  always @(posedge clk) exe_new_acc <= exe_model(exe_opcode, exe_imm, exe_acc);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  instr;
    int unsigned lat;
    logic [7:0]  exp_acc;
    logic        exp_alu;
    logic        exp_mem;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [7:0] a0, w0;
    logic we0;

    vecs[0] = '{{OP_LI,   3'd5}, 4, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{{OP_ADDI, 3'd2}, 4, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{{OP_ST,   3'd0}, 3, 8'h07, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{{OP_LI,   3'd1}, 4, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{{OP_LD,   3'd0}, 3, 8'h07, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hE0,           2, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{{OP_LD,   3'd1}, 3, 8'h0A, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{{OP_ADDI, 3'd7}, 4, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'hC8,           2, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'h6C,           4, 8'h11, 1'b1, 1'b0, 1'b0};

    // Reset state
    fill_mem(8'h00);
    for (int i = 0; i < 10; i++) mem[i] = vecs[i].instr;
    mem[10] = {OP_HALT, 3'b111};
    do_reset();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_exe_fields", {exe_opcode, exe_imm, exe_register}, 0);
    chk("rst_exe_class", {exe_is_alu_op, exe_is_mem_op, exe_mem_rw}, 0);

    // Table-driven program, zero-wait memory
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("v%0d_fetch_req", i), mem_req, 1);
      chk($sformatf("v%0d_fetch_addr", i), mem_addr, i);
      chk($sformatf("v%0d_fetch_we", i), mem_we, 0);
      @(negedge clk);
      chk($sformatf("v%0d_opcode", i), exe_opcode, vecs[i].instr[7:3]);
      chk($sformatf("v%0d_imm", i), exe_imm, vecs[i].instr[2:0]);
      chk($sformatf("v%0d_class", i), {exe_is_alu_op, exe_is_mem_op, exe_mem_rw},
          {vecs[i].exp_alu, vecs[i].exp_mem, vecs[i].exp_rw});
      chk($sformatf("v%0d_pc", i), pc, i + 1);
      repeat (vecs[i].lat - 1) @(negedge clk);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].exp_acc);
    end
    chk("st_mem0", mem[0], 8'h07);
    repeat (3) @(negedge clk);
    chk("prog_end_halted", halted, 1);

    // Store with three wait states: address/data held until ack
    fill_mem(8'h00);
    mem[0] = {OP_LI, 3'd3};
    mem[1] = {OP_ST, 3'd2};
    ack_delay = 3;
    do_reset();
    n = 0;
    while (!(mem_req && mem_we) && n < 60) begin @(negedge clk); n++; end
    chk("st_req_seen", mem_req && mem_we, 1);
    chk("st_addr", mem_addr, 8'h02);
    chk("st_wdata", mem_wdata, 8'h03);
    a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
    n = 0; bad = 0;
    while (!mem_ack && n < 20) begin
      if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0 || mem_req !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) bad++;
    chk("st_wait_cycles", n, 3);
    chk("st_stable", bad, 0);
    @(negedge clk);
    chk("st_acc_kept", acc, 8'h03);
    chk("st_written", mem[2], 8'h03);
    chk("st_next_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h02});
    ack_delay = 0;

    // Load from zero page
    fill_mem(8'h00);
    mem[0] = {OP_LD, 3'd4};
    mem[4] = 8'hA5;
    do_reset();
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("ld_acc", acc, 8'hA5);
    chk("ld_pc", pc, 8'h01);
    chk("ld_next_fetch", {mem_req, mem_addr}, {1'b1, 8'h01});

    // HALT at pc 2; stray acks are ignored while halted
    fill_mem(8'hE0);
    mem[2] = 8'hFF;
    do_reset();
    n = 0;
    while (!halted && n < 100) begin @(negedge clk); n++; end
    chk("halt_reached", halted, 1);
    chk("halt_pc", pc, 8'h03);
    bad = 0;
    ack_force = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
    end
    ack_force = 1'b0;
    chk("halt_quiet", bad, 0);
    chk("halt_pc_hold", pc, 8'h03);
    do_reset();
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc", pc, 8'h00);
    @(negedge clk);
    chk("halt_rst_fetch", {mem_req, mem_addr}, {1'b1, 8'h00});

    // PC wrap through a field of NOPs
    fill_mem(8'hE0);
    do_reset();
    n = 0;
    while (!(mem_req && !mem_we && mem_addr == 8'hFF) && n < 1000) begin @(negedge clk); n++; end
    chk("wrap_fetch_ff", mem_addr, 8'hFF);
    @(negedge clk);
    chk("wrap_pc", pc, 8'h00);
    @(negedge clk);
    chk("wrap_fetch_00", {mem_req, mem_addr}, {1'b1, 8'h00});

    // Reset during a pending fetch with a simultaneous ack
    fill_mem(8'h00);
    mem[0] = {OP_ST, 3'd3};
    ack_delay = 10;
    do_reset();
    repeat (3) @(negedge clk);
    chk("rstmid_pending", {mem_req, pc}, {1'b1, 8'h00});
    reset = 1'b1;
    ack_force = 1'b1;
    @(negedge clk);
    chk("rstmid_pc", pc, 8'h00);
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_ir", {exe_opcode, exe_is_mem_op}, 0);
    reset = 1'b0;
    ack_force = 1'b0;
    @(negedge clk);
    chk("rstmid_refetch", {mem_req, mem_addr}, {1'b1, 8'h00});
    ack_delay = 0;

`ifdef VTISA_SINGLE_STEP_EN
    // Single-step: park after each instruction, one pulse releases exactly one
    fill_mem(8'hE0);
    mem[0] = {OP_LI, 3'd5};
    step = 1'b0;
    do_reset();
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("ss_acc", acc, 8'h05);
    chk("ss_wait", step_wait, 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || step_wait !== 1'b1) bad++;
    end
    chk("ss_parked", bad, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 0;
    repeat (10) begin
      if (mem_req) n++;
      @(negedge clk);
    end
    chk("ss_one_fetch", n, 1);
    chk("ss_pc", pc, 8'h02);
    chk("ss_wait_again", step_wait, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vtisa_sequencer.md
Name: vtisa_sequencer

Overview:
- Multi-cycle control unit for the vtisa core.
- Fetches 8-bit instructions over a shared req/ack memory port, then decodes them into opcode and operand fields.
- Drives the registered executor datapath, performs load/store transfers, and owns the PC and accumulator.
- Sits between the memory/bus adapter and the executor; it is the only master of both.

Parameters:
- ADDR_W, 8, PC and memory address width in bits; minimum 4.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mem_req  output  1  memory request; held until acknowledged
- mem_we  output  1  1 = write (store), 0 = read (fetch/load)
- mem_addr  output  ADDR_W  transfer address
- mem_wdata  output  8  store data (accumulator)
- mem_rdata  input  8  read data; valid when mem_ack is high
- mem_ack  input  1  single-cycle transfer completion
- exe_opcode  output  5  instruction bits [7:3] to executor
- exe_imm  output  3  instruction bits [2:0] as immediate
- exe_register  output  3  instruction bits [2:0] as register index
- exe_is_alu_op  output  1  decoded ALU class
- exe_is_mem_op  output  1  decoded memory class
- exe_mem_rw  output  1  opcode[0] for memory class; 1 = store
- exe_acc  output  8  current accumulator to executor
- exe_new_acc  input  8  executor result; registered, valid the cycle after EXEC
- acc  output  8  architectural accumulator
- pc  output  ADDR_W  architectural PC
- halted  output  1  high once HALT has retired

Behaviour:
- Reset values:
  - state = FETCH, pc = RESET_PC, acc = 0, instruction register ir = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, halted = 0.
  - Every exe_* output resolves to 0 from ir = 0.
  - Reset mid-transfer aborts the transfer. An mem_ack arriving in the reset cycle is ignored.
- Decode classes (from ir[7:3]):
  - opcode[4] = 0: ALU class; includes OP_LI = 5'b00000.
  - opcode[4:3] = 2'b10: memory class. opcode[0] = 0 is LD, 1 is ST.
  - 5'b11111: HALT.
  - Other 11xxx opcodes: NOP.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On mem_ack: ir <= mem_rdata, pc <= pc + 1 (wraps modulo 2^ADDR_W), go to DECODE. mem_req drops the cycle after ack.
  - DECODE: exe_* outputs become valid from ir and stay stable through WB.
    - ALU → EXEC; memory → MEM; NOP → FETCH; HALT → HALT.
  - EXEC: one cycle; the executor samples its inputs at the end of this cycle → WB.
  - MEM: mem_addr = zero-extended ir[2:0] (8-byte zero page).
    - LD: mem_we = 0. On ack: acc <= mem_rdata → FETCH.
    - ST: mem_we = 1, mem_wdata = acc. On ack → FETCH; acc unchanged.
  - WB: acc <= exe_new_acc → FETCH.
  - HALT: halted = 1 and mem_req = 0 permanently; only reset exits.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req = 1.
  - mem_ack is ignored when mem_req = 0.
  - Wait states are unbounded; there is no timeout.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD/ST: 3 cycles.
  - NOP: 2 cycles.
- pc wraps from 2^ADDR_W−1 to 0 silently.

Optional Feature:
- Macro: VTISA_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and output step_wait (1 bit).
  - Every transition that would enter FETCH goes to state STEP_WAIT instead, with step_wait = 1.
  - STEP_WAIT → FETCH on the first cycle step = 1; a step held high advances only one instruction per rising edge of step.
  - Reset enters FETCH directly, without a STEP_WAIT.
- When not defined: no extra ports or state, and the behaviour is exactly as above.

Decomposition:
- Package vtisa_pkg holds:
  - Opcode localparams: OP_LI, OP_LD = 5'b10000, OP_ST = 5'b10001, OP_HALT = 5'b11111.
  - The state enum typedef.
  - Class-decode functions is_alu(op) and is_mem(op).
- The executor also imports vtisa_pkg.
- One sub-module, vtisa_decode: purely combinational, ir → exe_* fields and class bits.
- The FSM, PC and accumulator remain in vtisa_sequencer.

Test Plan:
- Zero-wait memory, mem[0] = 8'h05 (OP_LI, imm 5), executor model returns 5 → after 4 cycles acc = 5, pc = 1, and FETCH of address 1 is issued.
- Program {LI 3; ST 2}, ack delayed 3 cycles → mem_addr = 2, mem_we = 1, mem_wdata = 3, all held stable until ack; acc stays 3.
- mem[4] = 8'hA5 with program LD 4 → acc = 8'hA5 after ack; pc advances by 1.
- HALT (8'hFF) at pc = 2 → halted = 1; mem_req stays 0 for 20 cycles; a reset then restarts fetch at RESET_PC.
- pc = 8'hFF executing NOP → next fetch address 8'h00. Reset asserted during a pending fetch, then ack → ack ignored, state = FETCH, pc = RESET_PC.
- With VTISA_SINGLE_STEP_EN: step held low → no second fetch, step_wait = 1. One-cycle step pulse → exactly one instruction retires.
